// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared ALU codes, opcodes, FSM states and instruction layout for the sequencer
package alu_seq_pkg;
  localparam logic [2:0] ALU_PASSA = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_PASSB = 3'd2;
  localparam logic [2:0] ALU_ADD   = 3'd3;
  localparam logic [2:0] ALU_NAND  = 3'd4;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_NAND = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JNC  = 4'hA;
  localparam logic [3:0] OP_JNZ  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} stateT;
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] k;
  } instrT;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: combinational decode of the held instruction into datapath strobes and branch outcome
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  stateT      state,
  input  instrT      ir,
  input  logic       flagC,
  input  logic       flagZ,
  output logic [2:0] control,
  output logic       loadAcu,
  output logic       enableOutALU,
  output logic       out_strobe,
  output logic       flag_we,
  output logic       jump_taken
);
  logic exec;
  assign exec = state == EXEC;
  always_comb begin
    control = !exec ? ALU_PASSA :
              ir.opcode == OP_LIT ? ALU_PASSB :
              ir.opcode == OP_ADD ? ALU_ADD :
              (ir.opcode == OP_SUB || ir.opcode == OP_CMP) ? ALU_SUB :
              ir.opcode == OP_NAND ? ALU_NAND : ALU_PASSA;
    loadAcu = exec && ir.opcode inside {[OP_LIT:OP_NAND]};
    flag_we = exec && ir.opcode inside {[OP_LIT:OP_CMP]};
    enableOutALU = exec && ir.opcode == OP_OUT;
    out_strobe = exec && ir.opcode == OP_OUT;
    jump_taken = exec && (ir.opcode == OP_JMP ||
                          (ir.opcode == OP_JC && flagC) || (ir.opcode == OP_JZ && flagZ) ||
                          (ir.opcode == OP_JNC && !flagC) || (ir.opcode == OP_JNZ && !flagZ));
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: two-cycle fetch/execute controller driving the 4-bit ALU/accumulator datapath
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] instr,
  output logic [3:0] pc,
  input  logic       C,
  input  logic       Z,
  output logic [2:0] control,
  output logic [3:0] dataIn,
  output logic       loadAcu,
  output logic       enableOutALU,
  output logic       busy,
  output logic       halted,
  output logic       out_strobe
);
  stateT state, nextState;
  instrT ir;
  logic flagC, flagZ, flagWe, jumpTaken, restart;
  alu_seq_decode decode (
    .state(state), .ir(ir), .flagC(flagC), .flagZ(flagZ),
    .control(control), .loadAcu(loadAcu), .enableOutALU(enableOutALU),
    .out_strobe(out_strobe), .flag_we(flagWe), .jump_taken(jumpTaken)
  );
  assign restart = start && (state == IDLE || state == HALT);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  always_comb
    nextState = restart ? FETCH :
                state == FETCH ? EXEC :
                state == EXEC ? (ir.opcode == OP_HALT ? HALT : FETCH) : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= 4'd0;
      ir <= '0;
      flagC <= 1'b0;
      flagZ <= 1'b0;
    end else begin
      if (restart) pc <= 4'd0;
      else if (state == EXEC) pc <= jumpTaken ? ir.k : pc + 4'd1;
      if (state == FETCH) ir <= instr;
      if (restart && state == HALT) begin
        flagC <= 1'b0;
        flagZ <= 1'b0;
      end else if (flagWe) begin
        flagC <= C;
        flagZ <= Z;
      end
    end
  always_comb begin
    busy = state == FETCH || state == EXEC;
    halted = state == HALT;
    dataIn = state == EXEC ? ir.k : 4'd0;
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: runs programs on a behavioural datapath and checks against an instruction-level model
module tb_alu_sequencer;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic C, Z, loadAcu, enableOutALU, busy, halted, out_strobe;
  logic [7:0] instr;
  logic [3:0] pc, dataIn;
  logic [2:0] control;
  logic [7:0] mem [16];
  logic [3:0] acc = 4'd0;
  logic [4:0] r;
  int nChecks = 0, nFail = 0;
  int busyCycles, loads, outs, ens, lastOut, stray;
  int mPc, mAcc = 0, mFc, mFz, mHalt, mSteps, mLoads, mOuts, mLastOut;

  always #5 clk = ~clk;
  assign instr = mem[pc];
  always_comb
    r = control == 3'd1 ? {1'b0, acc} - {1'b0, dataIn} :
        control == 3'd2 ? {1'b0, dataIn} :
        control == 3'd3 ? {1'b0, acc} + {1'b0, dataIn} :
        control == 3'd4 ? {1'b0, ~(acc & dataIn)} : {1'b0, acc};
  assign C = r[4];
  assign Z = r[3:0] == 4'd0;
  always @(posedge clk) if (loadAcu) acc <= r[3:0];

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc), .C(C), .Z(Z),
    .control(control), .dataIn(dataIn), .loadAcu(loadAcu), .enableOutALU(enableOutALU),
    .busy(busy), .halted(halted), .out_strobe(out_strobe)
  );

  task automatic modelRun(input int k);
    int op, kk, nxt, res;
    mPc = 0; mFc = 0; mFz = 0; mHalt = 0; mSteps = 0; mLoads = 0; mOuts = 0; mLastOut = 0;
    for (int i = 0; i < k && mHalt == 0; i++) begin
      op = int'(mem[mPc][7:4]);
      kk = int'(mem[mPc][3:0]);
      nxt = (mPc + 1) % 16;
      res = 0;
      mSteps++;
      case (op)
        1: res = kk;
        2: res = mAcc + kk;
        3, 5: res = mAcc - kk;
        4: res = ~(mAcc & kk) & 15;
        6: begin mOuts++; mLastOut = mAcc; end
        7: nxt = kk;
        8: if (mFc != 0) nxt = kk;
        9: if (mFz != 0) nxt = kk;
        10: if (mFc == 0) nxt = kk;
        11: if (mFz == 0) nxt = kk;
        15: mHalt = 1;
        default: ;
      endcase
      if (op >= 1 && op <= 5) begin
        mFc = (op == 2) ? int'(res > 15) : (op == 3 || op == 5) ? int'(res < 0) : 0;
        mFz = int'((res & 15) == 0);
        if (op != 5) begin mAcc = res & 15; mLoads++; end
      end
      mPc = nxt;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (busy) busyCycles++;
    if (loadAcu) loads++;
    if (out_strobe) begin outs++; lastOut = int'(acc); end
    if (enableOutALU) ens++;
    if (!busy && (loadAcu || enableOutALU || out_strobe || control != 3'd0 || dataIn != 4'd0)) stray++;
  endtask

  task automatic runProg(input int k, input int poke);
    busyCycles = 0; loads = 0; outs = 0; ens = 0; lastOut = 0; stray = 0;
    modelRun(k);
    start = 1'b1;
    step();
    for (int i = 1; i < 2 * k; i++) begin
      start = (i == poke || i == poke + 1);
      step();
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    reset = 1'b0; #2; reset = 1'b1;
  endtask

  task automatic loadMem(input logic [7:0] p [16]);
    for (int i = 0; i < 16; i++) mem[i] = p[i];
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    #12;
    nChecks++; if (pc !== 4'd0) begin nFail++; $display("FAIL reset_pc got %0d want 0", pc); end
    nChecks++; if ({busy, halted, loadAcu, enableOutALU, out_strobe} !== 5'b0) begin nFail++; $display("FAIL reset_flags got %b want 00000", {busy, halted, loadAcu, enableOutALU, out_strobe}); end
    nChecks++; if ({control, dataIn} !== 7'd0) begin nFail++; $display("FAIL reset_bus got %h want 0", {control, dataIn}); end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (busy !== 1'b0) begin nFail++; $display("FAIL idle_hold got busy=%b want 0", busy); end
  endtask

  task automatic test_arith_branch();
    loadMem('{8'h1F, 8'h26, 8'h85, 8'hF0, 8'h00, 8'h60, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    runProg(8, -1);
    nChecks++; if (acc !== 4'd5 || int'(acc) != mAcc) begin nFail++; $display("FAIL arith_acc got %0d want 5", acc); end
    nChecks++; if (halted !== 1'b1 || pc !== 4'd7) begin nFail++; $display("FAIL arith_halt got halted=%b pc=%0d want 1 pc=7", halted, pc); end
    nChecks++; if (outs != 1 || ens != 1 || lastOut != 5) begin nFail++; $display("FAIL arith_out got outs=%0d ens=%0d val=%0d want 1 1 5", outs, ens, lastOut); end
    nChecks++; if (busyCycles != 2 * mSteps || busyCycles != 10) begin nFail++; $display("FAIL arith_cycles got %0d want %0d", busyCycles, 2 * mSteps); end
    nChecks++; if (loads != 2 || stray != 0) begin nFail++; $display("FAIL arith_loads got loads=%0d stray=%0d want 2 0", loads, stray); end
  endtask

  task automatic test_start();
    runProg(8, 3);
    nChecks++; if (pc !== 4'd7 || halted !== 1'b1 || busyCycles != 10) begin nFail++; $display("FAIL start_busy got pc=%0d halted=%b cyc=%0d want 7 1 10", pc, halted, busyCycles); end
    loadMem('{8'h83, 8'hF0, 8'h00, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    runProg(4, -1);
    nChecks++; if (int'(pc) != mPc || pc !== 4'd2 || halted !== 1'b1) begin nFail++; $display("FAIL start_restart got pc=%0d halted=%b want 2 1", pc, halted); end
  endtask

  task automatic test_compare();
    loadMem('{8'h1A, 8'h5A, 8'h95, 8'hF0, 8'h00, 8'h58, 8'h99, 8'h60, 8'hF0, 8'hF0, 0, 0, 0, 0, 0, 0});
    runProg(10, -1);
    nChecks++; if (int'(pc) != mPc || pc !== 4'd9) begin nFail++; $display("FAIL cmp_branch got pc=%0d want 9", pc); end
    nChecks++; if (loads != 1 || acc !== 4'd10 || lastOut != 10) begin nFail++; $display("FAIL cmp_acc got loads=%0d acc=%0d out=%0d want 1 10 10", loads, acc, lastOut); end
  endtask

  task automatic test_undefined();
    loadMem('{8'h10, 8'hC3, 8'hD0, 8'hE7, 8'h97, 8'hF0, 8'h00, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0});
    runProg(8, -1);
    nChecks++; if (int'(pc) != mPc || pc !== 4'd8) begin nFail++; $display("FAIL undef_pc got %0d want 8", pc); end
    nChecks++; if (loads != 1 || ens != 0 || busyCycles != 12) begin nFail++; $display("FAIL undef_strobes got loads=%0d ens=%0d cyc=%0d want 1 0 12", loads, ens, busyCycles); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    runProg(16, -1);
    nChecks++; if (pc !== 4'd0 || int'(pc) != mPc) begin nFail++; $display("FAIL wrap_pc got %0d want 0", pc); end
    nChecks++; if (halted !== 1'b0 || loads != 0 || busyCycles != 32) begin nFail++; $display("FAIL wrap_run got halted=%b loads=%0d cyc=%0d want 0 0 32", halted, loads, busyCycles); end
    repeat (2) @(posedge clk);
    #1;
    nChecks++; if (pc !== 4'd1) begin nFail++; $display("FAIL wrap_next got %0d want 1", pc); end
    doReset();
  endtask

  task automatic test_reset_mid_exec();
    loadMem('{8'h13, 8'h24, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    busyCycles = 0; loads = 0; outs = 0; ens = 0; stray = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    nChecks++; if (loadAcu !== 1'b1 || control !== 3'd3) begin nFail++; $display("FAIL midexec_setup got load=%b ctl=%0d want 1 3", loadAcu, control); end
    reset = 1'b0;
    #1;
    nChecks++; if (loadAcu !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || control !== 3'd0) begin nFail++; $display("FAIL midexec_async got load=%b pc=%0d busy=%b ctl=%0d want 0 0 0 0", loadAcu, pc, busy, control); end
    @(posedge clk); #1;
    nChecks++; if (acc !== 4'd3) begin nFail++; $display("FAIL midexec_acc got %0d want 3", acc); end
    reset = 1'b1;
    mAcc = 3;
  endtask

  task automatic test_random();
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
      doReset();
      runProg(20, -1);
      nChecks++; if (int'(pc) != mPc || int'(halted) != mHalt) begin nFail++; $display("FAIL rand%0d_pc got pc=%0d halted=%b want %0d %0d", t, pc, halted, mPc, mHalt); end
      nChecks++; if (int'(acc) != mAcc || loads != mLoads) begin nFail++; $display("FAIL rand%0d_acc got acc=%0d loads=%0d want %0d %0d", t, acc, loads, mAcc, mLoads); end
      nChecks++; if (outs != mOuts || ens != mOuts || lastOut != mLastOut) begin nFail++; $display("FAIL rand%0d_out got outs=%0d ens=%0d val=%0d want %0d %0d %0d", t, outs, ens, lastOut, mOuts, mOuts, mLastOut); end
      nChecks++; if (busyCycles != 2 * mSteps || stray != 0) begin nFail++; $display("FAIL rand%0d_cycles got cyc=%0d stray=%0d want %0d 0", t, busyCycles, stray, 2 * mSteps); end
    end
  endtask

  initial begin
    test_reset();
    test_arith_branch();
    test_start();
    test_compare();
    test_undefined();
    test_wrap();
    test_reset_mid_exec();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
